// File: rtl/dlsc_pcie_s6_outbound_read_sched_pkg.sv
// ---------------------------------------------------------------------------
// dlsc_pcie_s6_outbound_read_sched_pkg
//   Shared definitions for the outbound read-request scheduler:
//   - MRRS code constants and the code-to-DW conversion used when a command
//     is accepted.
//   - Scheduler FSM state encoding.
//   - SEG_W: width of a segment length in DWs (1..1024).
// ---------------------------------------------------------------------------
package dlsc_pcie_s6_outbound_read_sched_pkg;

    // PCIe Max_Read_Request_Size codes (Device Control register encoding)
    localparam logic [2:0] MRRS_128B  = 3'd0;
    localparam logic [2:0] MRRS_256B  = 3'd1;
    localparam logic [2:0] MRRS_512B  = 3'd2;
    localparam logic [2:0] MRRS_1024B = 3'd3;
    localparam logic [2:0] MRRS_2048B = 3'd4;
    localparam logic [2:0] MRRS_4096B = 3'd5;

    // A segment is at most 1024 DWs, which needs 11 bits
    localparam int SEG_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ALLOC = 2'd2,
        ST_ISSUE = 2'd3
    } rd_state_t;

    // MRRS code -> DW count (32 << code); reserved codes behave as 4096B
    function automatic logic [SEG_W-1:0] mrrs_to_dw(input logic [2:0] code);
        logic [2:0] c;
        c = (code > MRRS_4096B) ? MRRS_4096B : code;
        return SEG_W'(32) << c;
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_read_sched_if.sv
// ---------------------------------------------------------------------------
// dlsc_pcie_s6_outbound_read_sched_if
//   Bus bundle for the read scheduler:
//   - cmd_*      : read command channel (valid/ready), DW address + DW count-1
//   - rd_tlp_h_* : read header channel towards the TLP builder (valid/ready)
//   - tag_free_* : tag return pulses from the completion path
//   modport slave  : the scheduler side
//   modport master : the side issuing commands / sinking headers / freeing tags
// ---------------------------------------------------------------------------
interface dlsc_pcie_s6_outbound_read_sched_if #(
    parameter int ADDR = 32,
    parameter int LEN  = 10,
    parameter int TAG  = 5
);
    logic              cmd_ready;
    logic              cmd_valid;
    logic [ADDR-3:0]   cmd_addr;
    logic [LEN-1:0]    cmd_len;

    logic              rd_tlp_h_ready;
    logic              rd_tlp_h_valid;
    logic [ADDR-3:0]   rd_tlp_h_addr;
    logic [9:0]        rd_tlp_h_len;
    logic [TAG-1:0]    rd_tlp_h_tag;
    logic [3:0]        rd_tlp_h_be_first;
    logic [3:0]        rd_tlp_h_be_last;

    logic              tag_free_valid;
    logic [TAG-1:0]    tag_free_tag;

    modport slave (
        output cmd_ready,
        input  cmd_valid, cmd_addr, cmd_len,
        input  rd_tlp_h_ready,
        output rd_tlp_h_valid, rd_tlp_h_addr, rd_tlp_h_len, rd_tlp_h_tag,
        output rd_tlp_h_be_first, rd_tlp_h_be_last,
        input  tag_free_valid, tag_free_tag
    );

    modport master (
        input  cmd_ready,
        output cmd_valid, cmd_addr, cmd_len,
        output rd_tlp_h_ready,
        input  rd_tlp_h_valid, rd_tlp_h_addr, rd_tlp_h_len, rd_tlp_h_tag,
        input  rd_tlp_h_be_first, rd_tlp_h_be_last,
        output tag_free_valid, tag_free_tag
    );
endinterface

// File: rtl/dlsc_pcie_s6_outbound_read_sched_tag_pool.sv
// ---------------------------------------------------------------------------
// dlsc_pcie_s6_outbound_read_sched_tag_pool
//   Tag allocator: a 2^TAG bitmap of in-use tags.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset (all tags free)
//     alloc_req    : allocator wants a tag this cycle
//     alloc_ack    : a tag was granted (alloc_req and a free tag exists)
//     alloc_tag    : lowest-numbered free tag
//     free_valid   : return free_tag to the pool this cycle
//     free_tag     : tag being returned
//     outstanding  : number of tags currently allocated
//     err_free     : sticky, set when an already-free tag is returned
// ---------------------------------------------------------------------------
module dlsc_pcie_s6_outbound_read_sched_tag_pool #(
    parameter int TAG = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           alloc_req,
    output logic           alloc_ack,
    output logic [TAG-1:0] alloc_tag,
    input  logic           free_valid,
    input  logic [TAG-1:0] free_tag,
    output logic [TAG:0]   outstanding,
    output logic           err_free
);
    localparam int N = 1 << TAG;

    logic [N-1:0] used_q, used_d;
    logic [TAG:0] cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         any_free;
    logic [TAG-1:0] low_free;
    logic         free_ok;

    // Priority encoder over the registered bitmap. A tag being freed this
    // cycle is still marked used here, so it can never be picked while it
    // is being returned; it becomes available next cycle.
    always_comb begin
        any_free = 1'b0;
        low_free = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                any_free = 1'b1;
                low_free = TAG'(i);
            end
        end
    end

    assign alloc_ack = alloc_req && any_free;
    assign alloc_tag = low_free;
    assign free_ok   = free_valid && used_q[free_tag];

    always_comb begin
        used_d = used_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (alloc_ack) begin
            used_d[alloc_tag] = 1'b1;
        end
        if (free_valid) begin
            if (used_q[free_tag]) begin
                used_d[free_tag] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        case ({alloc_ack, free_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            used_q <= used_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign outstanding = cnt_q;
    assign err_free    = err_q;

endmodule

// File: rtl/dlsc_pcie_s6_outbound_read_sched.sv
// ---------------------------------------------------------------------------
// dlsc_pcie_s6_outbound_read_sched
//   Read-request scheduler in front of the outbound TLP read header port.
//   Takes one DW-granular read command at a time, splits it at MRRS-aligned
//   boundaries (which also keeps every segment inside a 4KB page), grabs a
//   tag per segment and issues one read header per segment.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     bus (slave)       : cmd_* command channel, rd_tlp_h_* header channel,
//                         tag_free_* tag returns
//     max_read_request  : MRRS code, sampled when a command is accepted
//     tags_outstanding  : number of tags currently allocated
//     busy              : a command is being processed
//     err_free          : sticky, a free tag was returned again
// ---------------------------------------------------------------------------
module dlsc_pcie_s6_outbound_read_sched
    import dlsc_pcie_s6_outbound_read_sched_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int LEN  = 10,
    parameter int TAG  = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    dlsc_pcie_s6_outbound_read_sched_if.slave  bus,
    input  logic [2:0]                         max_read_request,
    output logic [TAG:0]                       tags_outstanding,
    output logic                               busy,
    output logic                               err_free
);
    localparam int AW = ADDR - 2;
    localparam int RW = LEN + 1;
    localparam int CW = (RW > SEG_W) ? RW : SEG_W;

    rd_state_t        state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [SEG_W-1:0] mrrs_q, mrrs_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    logic             hv_q, hv_d;
    logic [AW-1:0]    ha_q, ha_d;
    logic [9:0]       hl_q, hl_d;
    logic [TAG-1:0]   ht_q, ht_d;
    logic [3:0]       hbl_q, hbl_d;

    logic [SEG_W-1:0] to_bnd;
    logic [SEG_W-1:0] seg_calc;
    logic             alloc_req;
    logic             alloc_ack;
    logic [TAG-1:0]   alloc_tag;

    // Distance to the next MRRS-aligned boundary and the resulting segment.
    // mrrs_q is a power of two <= 1024, so only the low 11 address bits matter.
    always_comb begin
        to_bnd = mrrs_q - (SEG_W'(addr_q) & (mrrs_q - SEG_W'(1)));
        if (CW'(rem_q) < CW'(to_bnd)) begin
            seg_calc = SEG_W'(rem_q);
        end else begin
            seg_calc = to_bnd;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        mrrs_d    = mrrs_q;
        seg_d     = seg_q;
        hv_d      = hv_q;
        ha_d      = ha_q;
        hl_d      = hl_q;
        ht_d      = ht_q;
        hbl_d     = hbl_q;
        alloc_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d  = bus.cmd_addr;
                    rem_d   = RW'(bus.cmd_len) + RW'(1);
                    mrrs_d  = mrrs_to_dw(max_read_request);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                seg_d   = seg_calc;
                state_d = ST_ALLOC;
            end
            ST_ALLOC: begin
                alloc_req = 1'b1;
                if (alloc_ack) begin
                    hv_d    = 1'b1;
                    ha_d    = addr_q;
                    hl_d    = seg_q[9:0];    // 1024 wraps to 0 as the TLP encoding wants
                    ht_d    = alloc_tag;
                    hbl_d   = (seg_q == SEG_W'(1)) ? 4'h0 : 4'hF;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.rd_tlp_h_ready) begin
                    hv_d    = 1'b0;
                    addr_d  = addr_q + AW'(seg_q);
                    rem_d   = rem_q - RW'(seg_q);
                    state_d = (rem_q == RW'(seg_q)) ? ST_IDLE : ST_CALC;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Payload/working registers need no reset; only control is cleared.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        rem_q  <= rem_d;
        mrrs_q <= mrrs_d;
        seg_q  <= seg_d;
        ha_q   <= ha_d;
        hl_q   <= hl_d;
        ht_q   <= ht_d;
        hbl_q  <= hbl_d;
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            hv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            hv_q        <= hv_d;
        end
    end

    dlsc_pcie_s6_outbound_read_sched_tag_pool #(
        .TAG (TAG)
    ) u_tag_pool (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_ack   (alloc_ack),
        .alloc_tag   (alloc_tag),
        .free_valid  (bus.tag_free_valid),
        .free_tag    (bus.tag_free_tag),
        .outstanding (tags_outstanding),
        .err_free    (err_free)
    );

    assign bus.cmd_ready         = cmd_ready_q;
    assign bus.rd_tlp_h_valid    = hv_q;
    assign bus.rd_tlp_h_addr     = ha_q;
    assign bus.rd_tlp_h_len      = hl_q;
    assign bus.rd_tlp_h_tag      = ht_q;
    assign bus.rd_tlp_h_be_first = 4'hF;
    assign bus.rd_tlp_h_be_last  = hbl_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_sched.sv
// ---------------------------------------------------------------------------
// tb_dlsc_pcie_s6_outbound_read_sched
//   Directed vector table plus hand-written sequences for tag exhaustion,
//   double free, free/alloc collision and reset mid-issue, followed by a
//   randomized run with a tiling/boundary/tag-uniqueness scoreboard.
//   DUT built with LEN=11 so a 1025-DW command fits, and TAG=2 (4 tags).
// ---------------------------------------------------------------------------
module tb_dlsc_pcie_s6_outbound_read_sched;
    localparam int ADDR = 32;
    localparam int LEN  = 11;
    localparam int TAG  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     mrrs_code;
    logic [TAG:0]   outstanding;
    logic           busy;
    logic           err_free;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dlsc_pcie_s6_outbound_read_sched_if #(.ADDR(ADDR), .LEN(LEN), .TAG(TAG)) bus ();

    dlsc_pcie_s6_outbound_read_sched #(.ADDR(ADDR), .LEN(LEN), .TAG(TAG)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .max_read_request (mrrs_code),
        .tags_outstanding (outstanding),
        .busy             (busy),
        .err_free         (err_free)
    );

    typedef struct packed {
        logic [2:0]        mrrs;
        logic [29:0]       addr;
        logic [10:0]       len;
        logic [2:0]        nseg;
        logic [3:0][29:0]  ea;
        logic [3:0][10:0]  es;    // expected segment size in DWs
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [2:0] m, input logic [29:0] a, input logic [10:0] l,
                                input logic [2:0] n,
                                input logic [29:0] a0, input logic [10:0] s0,
                                input logic [29:0] a1, input logic [10:0] s1,
                                input logic [29:0] a2, input logic [10:0] s2,
                                input logic [29:0] a3, input logic [10:0] s3);
        vec_t v;
        v.mrrs = m; v.addr = a; v.len = l; v.nseg = n;
        v.ea[0] = a0; v.es[0] = s0;
        v.ea[1] = a1; v.es[1] = s1;
        v.ea[2] = a2; v.es[2] = s2;
        v.ea[3] = a3; v.es[3] = s3;
        return v;
    endfunction

    function automatic logic [63:0] hpack(input logic [29:0] a, input logic [9:0] l,
                                          input logic [1:0] t, input logic [3:0] bf,
                                          input logic [3:0] bl);
        return {14'd0, a, l, t, bf, bl};
    endfunction

    function automatic logic [63:0] hdut();
        return hpack(bus.rd_tlp_h_addr, bus.rd_tlp_h_len, bus.rd_tlp_h_tag,
                     bus.rd_tlp_h_be_first, bus.rd_tlp_h_be_last);
    endfunction

    // Expected header from a segment size (len field wraps 1024 to 0)
    function automatic logic [63:0] hexp(input logic [29:0] a, input logic [10:0] s,
                                         input logic [1:0] t);
        return hpack(a, s[9:0], t, 4'hF, (s == 11'd1) ? 4'h0 : 4'hF);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int waits);
        waits = 0;
        while (!bus.rd_tlp_h_valid && waits < 60) begin
            step();
            waits++;
        end
        if (!bus.rd_tlp_h_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: header valid timeout after %0d cycles, expected valid", name, waits);
        end
    endtask

    task automatic send_cmd(input logic [2:0] m, input logic [29:0] a, input logic [10:0] l);
        int w;
        mrrs_code     = m;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 60) begin
            step();
            w++;
        end
        if (!bus.cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready stayed 0, expected 1");
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic free_tag(input logic [1:0] t);
        bus.tag_free_valid = 1'b1;
        bus.tag_free_tag   = t;
        step();
        bus.tag_free_valid = 1'b0;
    endtask

    function automatic bit in_queue(input logic [1:0] q[$], input logic [1:0] t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [63:0] held_hdr;
        logic [1:0]  held[$];
        int          cmds_left, cycles, idx;
        bit          sb_active, stall_prev;
        logic [29:0] sb_addr;
        int          sb_rem, sb_mrrs, seg, bnd, exp_seg;
        logic [63:0] prev_hdr;

        vecs[0] = mk(3'd0, 30'h000, 11'd99, 3'd4,
                     30'h000, 11'd32, 30'h020, 11'd32, 30'h040, 11'd32, 30'h060, 11'd4);
        vecs[1] = mk(3'd0, 30'h01E, 11'd4, 3'd2,
                     30'h01E, 11'd2, 30'h020, 11'd3, 30'h0, 11'd0, 30'h0, 11'd0);
        vecs[2] = mk(3'd5, 30'h3FF, 11'd1024, 3'd2,
                     30'h3FF, 11'd1, 30'h400, 11'd1024, 30'h0, 11'd0, 30'h0, 11'd0);
        vecs[3] = mk(3'd1, 30'h0F0, 11'd99, 3'd3,
                     30'h0F0, 11'd16, 30'h100, 11'd64, 30'h140, 11'd20, 30'h0, 11'd0);
        vecs[4] = mk(3'd7, 30'h000, 11'd0, 3'd1,
                     30'h000, 11'd1, 30'h0, 11'd0, 30'h0, 11'd0, 30'h0, 11'd0);
        vecs[5] = mk(3'd2, 30'h3FFFFFF0, 11'd63, 3'd2,
                     30'h3FFFFFF0, 11'd16, 30'h000, 11'd48, 30'h0, 11'd0, 30'h0, 11'd0);
        vecs[6] = mk(3'd3, 30'h005, 11'd255, 3'd2,
                     30'h005, 11'd251, 30'h100, 11'd5, 30'h0, 11'd0, 30'h0, 11'd0);

        rst                = 1'b1;
        mrrs_code          = 3'd0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_addr       = '0;
        bus.cmd_len        = '0;
        bus.rd_tlp_h_ready = 1'b0;
        bus.tag_free_valid = 1'b0;
        bus.tag_free_tag   = '0;
        repeat (3) step();

        // Reset state
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_valid", 64'(bus.rd_tlp_h_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_free", 64'(err_free), 64'd0);
        rst = 1'b0;
        step();
        check("rst_cmd_ready_rise", 64'(bus.cmd_ready), 64'd1);

        // Directed vector table
        bus.rd_tlp_h_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            send_cmd(vecs[v].mrrs, vecs[v].addr, vecs[v].len);
            for (int s = 0; s < int'(vecs[v].nseg); s++) begin
                wait_valid($sformatf("vec%0d_seg%0d", v, s), w);
                check($sformatf("vec%0d_seg%0d_latency", v, s), 64'(w), 64'd2);
                check($sformatf("vec%0d_seg%0d_hdr", v, s), hdut(),
                      hexp(vecs[v].ea[s], vecs[v].es[s], 2'(s)));
                step();
            end
            check($sformatf("vec%0d_busy_done", v), 64'(busy), 64'd0);
            check($sformatf("vec%0d_valid_done", v), 64'(bus.rd_tlp_h_valid), 64'd0);
            check($sformatf("vec%0d_outstanding", v), 64'(outstanding), 64'(vecs[v].nseg));
            for (int t = 0; t < int'(vecs[v].nseg); t++) free_tag(2'(t));
            check($sformatf("vec%0d_outstanding_freed", v), 64'(outstanding), 64'd0);
        end

        // Tag exhaustion: 6 x 32-DW segments with only 4 tags
        send_cmd(3'd0, 30'h000, 11'd191);
        for (int s = 0; s < 4; s++) begin
            wait_valid($sformatf("exh_seg%0d", s), w);
            check($sformatf("exh_seg%0d_hdr", s), hdut(), hexp(30'(s * 32), 11'd32, 2'(s)));
            step();
        end
        repeat (10) step();
        check("exh_stall_valid", 64'(bus.rd_tlp_h_valid), 64'd0);
        check("exh_stall_outstanding", 64'(outstanding), 64'd4);
        check("exh_stall_busy", 64'(busy), 64'd1);
        free_tag(2'd2);
        wait_valid("exh_seg4", w);
        check("exh_seg4_hdr", hdut(), hexp(30'h080, 11'd32, 2'd2));
        step();
        repeat (5) step();
        check("exh_stall2_valid", 64'(bus.rd_tlp_h_valid), 64'd0);
        free_tag(2'd0);
        wait_valid("exh_seg5", w);
        check("exh_seg5_hdr", hdut(), hexp(30'h0A0, 11'd32, 2'd0));
        step();
        check("exh_busy_done", 64'(busy), 64'd0);
        check("exh_outstanding", 64'(outstanding), 64'd4);

        // Double free
        free_tag(2'd1);
        check("dfree_first_outstanding", 64'(outstanding), 64'd3);
        check("dfree_first_err", 64'(err_free), 64'd0);
        free_tag(2'd1);
        check("dfree_second_outstanding", 64'(outstanding), 64'd3);
        check("dfree_second_err", 64'(err_free), 64'd1);
        free_tag(2'd0);
        free_tag(2'd2);
        free_tag(2'd3);
        check("dfree_drain_outstanding", 64'(outstanding), 64'd0);
        check("dfree_err_sticky", 64'(err_free), 64'd1);

        // Free and allocate in the same cycle
        send_cmd(3'd0, 30'h000, 11'd0);
        wait_valid("coll_pre", w);
        check("coll_pre_hdr", hdut(), hexp(30'h000, 11'd1, 2'd0));
        step();
        send_cmd(3'd0, 30'h100, 11'd63);
        step();
        check("coll_alloc_cycle_valid", 64'(bus.rd_tlp_h_valid), 64'd0);
        free_tag(2'd0);
        check("coll_outstanding", 64'(outstanding), 64'd1);
        check("coll_seg0_hdr", hdut(), hexp(30'h100, 11'd32, 2'd1));
        step();
        wait_valid("coll_seg1", w);
        check("coll_seg1_hdr", hdut(), hexp(30'h120, 11'd32, 2'd0));
        step();
        check("coll_outstanding_end", 64'(outstanding), 64'd2);
        free_tag(2'd0);
        free_tag(2'd1);

        // Reset while a header is held under backpressure
        bus.rd_tlp_h_ready = 1'b0;
        send_cmd(3'd0, 30'h000, 11'd63);
        wait_valid("rstiss", w);
        held_hdr = hdut();
        repeat (2) step();
        check("rstiss_hold", {63'd0, bus.rd_tlp_h_valid} ^ hdut(), 64'd1 ^ held_hdr);
        rst = 1'b1;
        step();
        check("rstiss_valid", 64'(bus.rd_tlp_h_valid), 64'd0);
        check("rstiss_outstanding", 64'(outstanding), 64'd0);
        check("rstiss_busy", 64'(busy), 64'd0);
        check("rstiss_err_free", 64'(err_free), 64'd0);
        check("rstiss_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        step();
        check("rstiss_cmd_ready_rise", 64'(bus.cmd_ready), 64'd1);
        bus.rd_tlp_h_ready = 1'b1;
        send_cmd(3'd0, 30'h040, 11'd0);
        wait_valid("rstiss_new", w);
        check("rstiss_new_hdr", hdut(), hexp(30'h040, 11'd1, 2'd0));
        step();
        free_tag(2'd0);

        // Random commands with backpressure and random tag returns
        cmds_left  = 40;
        cycles     = 0;
        sb_active  = 1'b0;
        stall_prev = 1'b0;
        sb_addr    = '0;
        sb_rem     = 0;
        sb_mrrs    = 32;
        prev_hdr   = '0;
        while (cycles < 40000 && (cmds_left > 0 || sb_active)) begin
            cycles++;
            check("rand_outstanding", 64'(outstanding),
                  64'(held.size() + int'(bus.rd_tlp_h_valid)));
            check("rand_busy", 64'(busy), 64'(sb_active));
            if (stall_prev)
                check("rand_stable", {63'd0, bus.rd_tlp_h_valid} ^ hdut(), 64'd1 ^ prev_hdr);

            if (bus.cmd_valid) begin
                bus.cmd_valid = 1'b0;
                mrrs_code     = 3'($urandom_range(0, 7));
            end else if (!sb_active && cmds_left > 0 && bus.cmd_ready &&
                         $urandom_range(0, 3) == 0) begin
                mrrs_code     = 3'($urandom_range(0, 7));
                bus.cmd_addr  = 30'($urandom);
                bus.cmd_len   = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 130))
                                                           : 11'($urandom_range(0, 2047));
                bus.cmd_valid = 1'b1;
                sb_addr       = bus.cmd_addr;
                sb_rem        = int'(bus.cmd_len) + 1;
                sb_mrrs       = 32 << ((mrrs_code > 3'd5) ? 5 : int'(mrrs_code));
                sb_active     = 1'b1;
                cmds_left--;
            end else begin
                mrrs_code = 3'($urandom_range(0, 7));
            end

            bus.rd_tlp_h_ready = ($urandom_range(0, 2) != 0);
            stall_prev = 1'b0;
            if (bus.rd_tlp_h_valid) begin
                if (!bus.rd_tlp_h_ready) begin
                    stall_prev = 1'b1;
                    prev_hdr   = hdut();
                end else begin
                    seg     = (bus.rd_tlp_h_len == 10'd0) ? 1024 : int'(bus.rd_tlp_h_len);
                    bnd     = sb_mrrs - int'(sb_addr[10:0] & 11'(sb_mrrs - 1));
                    exp_seg = (sb_rem < bnd) ? sb_rem : bnd;
                    check("rand_active", 64'(sb_active), 64'd1);
                    check("rand_addr", 64'(bus.rd_tlp_h_addr), 64'(sb_addr));
                    check("rand_seg", 64'(seg), 64'(exp_seg));
                    check("rand_tag_reuse", 64'(in_queue(held, bus.rd_tlp_h_tag)), 64'd0);
                    check("rand_be", {56'd0, bus.rd_tlp_h_be_first, bus.rd_tlp_h_be_last},
                          {56'd0, 4'hF, (seg == 1) ? 4'h0 : 4'hF});
                    held.push_back(bus.rd_tlp_h_tag);
                    sb_addr = sb_addr + 30'(seg);
                    sb_rem  = sb_rem - seg;
                    if (sb_rem <= 0) sb_active = 1'b0;
                end
            end

            if (held.size() > 0 && $urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, held.size() - 1);
                bus.tag_free_tag   = held[idx];
                bus.tag_free_valid = 1'b1;
                held.delete(idx);
            end else begin
                bus.tag_free_valid = 1'b0;
            end
            step();
        end
        bus.tag_free_valid = 1'b0;
        bus.cmd_valid      = 1'b0;
        check("rand_all_done", 64'(cmds_left + int'(sb_active)), 64'd0);
        while (held.size() > 0) begin
            free_tag(held[0]);
            held.delete(0);
        end
        step();
        check("rand_final_outstanding", 64'(outstanding), 64'd0);
        check("rand_final_err_free", 64'(err_free), 64'd0);
        check("rand_final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
